memshare_sched_ctrl: RTL and testbench

MEMSHARE_SCHED_CTRL -- requirements
Module: memshare_sched_ctrl

---
 rtl/memshare_sched_pkg.sv | 19 +
 rtl/memshare_col_cnt.sv | 39 +++
 rtl/memshare_sched_ctrl.sv | 134 +++++++++++++
 tb/tb_memshare_sched_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memshare_sched_pkg.sv
// Shared types and defaults for the SCU memShare scheduler.
package memshare_sched_pkg;

  localparam int unsigned DEF_COL_NUM    = 4;
  localparam int unsigned DEF_COL_ADDR_W = 4;
  localparam int unsigned DEF_SHIFT_W    = 3;

  localparam logic NOSKID = 1'b0;
  localparam logic SKID   = 1'b1;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    READ_COL_ADDR = 3'd1,
    SHIFT_GEN     = 3'd2,
    MEM_SHARE     = 3'd3,
    DONE          = 3'd4
  } state_e;

endpackage

// File: rtl/memshare_col_cnt.sv
// Column index counter for one memShare operation, with terminal-count flag.
module memshare_col_cnt
  import memshare_sched_pkg::*;
#(
  parameter int unsigned COL_NUM = DEF_COL_NUM
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       inc_i,
  output logic [$clog2(COL_NUM)-1:0] idx_o,
  output logic                       last_o
);

  localparam int unsigned IDX_W = $clog2(COL_NUM);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == IDX_W'(COL_NUM - 1));

endmodule

// File: rtl/memshare_sched_ctrl.sv
// SCU memShare scheduler: per column reads the address ROM, samples the RFMU
// shift/compare, then requests shared memory. MEMSHARE_SCHED_ABORT_EN adds abort_i.
module memshare_sched_ctrl
  import memshare_sched_pkg::*;
#(
  parameter int unsigned COL_NUM    = DEF_COL_NUM,
  parameter int unsigned COL_ADDR_W = DEF_COL_ADDR_W,
  parameter int unsigned SHIFT_W    = DEF_SHIFT_W
) (
  input  logic                       sys_clk,
  input  logic                       rstn,
  input  logic                       start_i,
`ifdef MEMSHARE_SCHED_ABORT_EN
  input  logic                       abort_i,
`endif
  output logic                       col_addr_rd_o,
  output logic [$clog2(COL_NUM)-1:0] col_idx_o,
  input  logic                       col_addr_vld_i,
  input  logic [COL_ADDR_W-1:0]      col_addr_i,
  input  logic                       isGtr_i,
  input  logic [SHIFT_W-1:0]         shift_i,
  output logic                       mem_req_o,
  input  logic                       mem_gnt_i,
  output logic [COL_ADDR_W-1:0]      mem_addr_o,
  output logic [SHIFT_W-1:0]         mem_shift_o,
  output logic                       delta_o,
  output logic                       busy_o,
  output logic                       done_o
);

  state_e                  state_q, state_d;
  logic                    rd_q, rd_d;
  logic                    delta_q, delta_d;
  logic [COL_ADDR_W-1:0]   addr_q, addr_d;
  logic [SHIFT_W-1:0]      shift_q, shift_d;
  logic                    cnt_clr, cnt_inc, col_last;
  logic                    abort;

`ifdef MEMSHARE_SCHED_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  memshare_col_cnt #(
    .COL_NUM (COL_NUM)
  ) u_col_cnt (
    .clk_i  (sys_clk),
    .rst_ni (rstn),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .idx_o  (col_idx_o),
    .last_o (col_last)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    delta_d = delta_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        delta_d = NOSKID;
        if (start_i) begin
          state_d = READ_COL_ADDR;
          rd_d    = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      READ_COL_ADDR: begin
        if (col_addr_vld_i) begin
          addr_d  = col_addr_i;
          state_d = SHIFT_GEN;
        end
      end
      SHIFT_GEN: begin
        shift_d = shift_i;
        delta_d = delta_q ^ isGtr_i;
        state_d = MEM_SHARE;
      end
      MEM_SHARE: begin
        if (mem_gnt_i) begin
          if (col_last) begin
            state_d = DONE;
          end else begin
            cnt_inc = 1'b1;
            rd_d    = 1'b1;
            state_d = READ_COL_ADDR;
          end
        end
      end
      DONE: begin
        delta_d = NOSKID;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides whatever the state decided, including a pending grant.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      rd_d    = 1'b0;
      delta_d = NOSKID;
      cnt_inc = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      delta_q <= NOSKID;
      addr_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      delta_q <= delta_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign mem_req_o     = (state_q == MEM_SHARE);
  assign col_addr_rd_o = rd_q;
  assign delta_o       = delta_q & busy_o;
  assign mem_addr_o    = addr_q;
  assign mem_shift_o   = shift_q;

endmodule

// File: tb/tb_memshare_sched_ctrl.sv
// Self-checking bench for memshare_sched_ctrl (COL_NUM=4); abort case runs only
// when MEMSHARE_SCHED_ABORT_EN is defined.
module tb_memshare_sched_ctrl;

  localparam int unsigned CN = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          rstn, start, rd, vld, gtr, req, gnt, delta, busy, done;
  logic [1:0]    idx;
  logic [AW-1:0] addr_i, addr_o;
  logic [SW-1:0] sh_i, sh_o;
`ifdef MEMSHARE_SCHED_ABORT_EN
  logic          abort;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  logic [AW-1:0] last_addr = '0;

  memshare_sched_ctrl #(
    .COL_NUM    (CN),
    .COL_ADDR_W (AW),
    .SHIFT_W    (SW)
  ) dut (
    .sys_clk        (clk),
    .rstn           (rstn),
    .start_i        (start),
`ifdef MEMSHARE_SCHED_ABORT_EN
    .abort_i        (abort),
`endif
    .col_addr_rd_o  (rd),
    .col_idx_o      (idx),
    .col_addr_vld_i (vld),
    .col_addr_i     (addr_i),
    .isGtr_i        (gtr),
    .shift_i        (sh_i),
    .mem_req_o      (req),
    .mem_gnt_i      (gnt),
    .mem_addr_o     (addr_o),
    .mem_shift_o    (sh_o),
    .delta_o        (delta),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      isg;   // bit k = isGtr for column k
    logic [3:0][3:0] vd;    // vld delay per column
    logic [3:0][3:0] gd;    // grant delay per column
    logic            hold;  // keep start_i high while busy
    int              lat;   // expected start -> done cycles
    logic [3:0]      dexp;  // expected delta_o after each SHIFT_GEN
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return rd;
      1:       return req;
      default: return done;
    endcase
  endfunction

  task automatic wait_sig(input int which, output int n);
    n = 0;
    while (!sig(which) && n < 40) begin
      step;
      n++;
    end
    if (!sig(which)) n = -1;
  endtask

  task automatic run_op(input logic [3:0] isg, input logic [3:0][3:0] vd,
                        input logic [3:0][3:0] gd, input logic [3:0][AW-1:0] ad,
                        input logic [3:0][SW-1:0] sh, input logic hold,
                        input int exp_lat, input logic [3:0] dexp);
    int t0, n;
    t0 = cyc;
    start = 1'b1;
    step;
    start = hold;
    for (int k = 0; k < 4; k++) begin
      wait_sig(0, n);
      check("rd_latency", n, 0);
      check("col_idx", idx, k);
      for (int j = 0; j < int'(vd[k]); j++) begin
        vld = 1'b0;
        step;
        check("rd_one_cycle", rd, 0);
      end
      vld = 1'b1;
      addr_i = ad[k];
      step;
      vld = 1'b0;
      addr_i = ~ad[k];
      check("rd_in_shiftgen", rd, 0);
      check("req_in_shiftgen", req, 0);
      gtr = isg[k];
      sh_i = sh[k];
      step;
      gtr = 1'($urandom);
      sh_i = ~sh[k];
      vld = 1'b1;
      wait_sig(1, n);
      check("req_latency", n, 0);
      for (int j = 0; j <= int'(gd[k]); j++) begin
        check("req_held", req, 1);
        check("mem_addr", addr_o, ad[k]);
        check("mem_shift", sh_o, sh[k]);
        check("delta", delta, dexp[k]);
        gnt = (j == int'(gd[k]));
        step;
      end
      gnt = 1'b0;
      vld = 1'b0;
      check("req_drop", req, 0);
    end
    wait_sig(2, n);
    check("done_latency", cyc - t0, exp_lat);
    check("busy_in_done", busy, 1);
    start = 1'b0;
    step;
    check("done_pulse_one", done, 0);
    check("busy_after_done", busy, 0);
    check("delta_after_done", delta, 0);
    last_addr = ad[3];
  endtask

  initial begin
    logic [3:0][AW-1:0] ad;
    logic [3:0][SW-1:0] sh;
    logic [3:0][3:0]    vd, gd;
    logic [3:0]         isg, dexp;
    logic               d;
    int                 lat, dones;

    rstn = 1'b0; start = 1'b0; vld = 1'b0; gtr = 1'b0; gnt = 1'b0;
    addr_i = '0; sh_i = '0;
`ifdef MEMSHARE_SCHED_ABORT_EN
    abort = 1'b0;
`endif

    tbl[0] = '{isg:4'b0000, vd:16'h0000, gd:16'h0000, hold:1'b0, lat:13, dexp:4'b0000};
    tbl[1] = '{isg:4'b1101, vd:16'h0000, gd:16'h0000, hold:1'b0, lat:13, dexp:4'b1011};
    tbl[2] = '{isg:4'b0000, vd:16'h0000, gd:16'h0500, hold:1'b0, lat:18, dexp:4'b0000};
    tbl[3] = '{isg:4'b1111, vd:16'h0002, gd:16'h1000, hold:1'b0, lat:16, dexp:4'b0101};
    tbl[4] = '{isg:4'b0110, vd:16'h0010, gd:16'h0002, hold:1'b1, lat:16, dexp:4'b0010};

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", req, 0);
    check("rst_rd", rd, 0);
    check("rst_delta", delta, 0);
    check("rst_idx", idx, 0);
    check("rst_addr", addr_o, 0);
    check("rst_shift", sh_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    step;

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) begin
        ad[k] = AW'($urandom);
        sh[k] = SW'($urandom);
      end
      run_op(tbl[i].isg, tbl[i].vd, tbl[i].gd, ad, sh, tbl[i].hold, tbl[i].lat, tbl[i].dexp);
    end

    // Stray grant/valid/start-free IDLE cycles must not move anything.
    for (int i = 0; i < 3; i++) begin
      gnt = 1'b1; vld = 1'b1; addr_i = AW'($urandom);
      step;
      check("idle_busy", busy, 0);
      check("idle_req", req, 0);
      check("idle_rd", rd, 0);
      check("idle_addr", addr_o, last_addr);
    end
    gnt = 1'b0; vld = 1'b0;
    step;

    // Reset in MEM_SHARE of column 1.
    start = 1'b1; step; start = 1'b0;
    vld = 1'b1; addr_i = 4'hA; step; vld = 1'b0;
    gtr = 1'b1; sh_i = 3'd5; step; gtr = 1'b0;
    gnt = 1'b1; step; gnt = 1'b0;
    vld = 1'b1; addr_i = 4'h7; step; vld = 1'b0;
    sh_i = 3'd6; step;
    check("pre_rst_req", req, 1);
    check("pre_rst_idx", idx, 1);
    check("pre_rst_addr", addr_o, 4'h7);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_req", req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_idx", idx, 0);
    check("async_rst_addr", addr_o, 0);
    check("async_rst_shift", sh_o, 0);
    check("async_rst_delta", delta, 0);
    check("async_rst_rd", rd, 0);
    @(negedge clk);
    rstn = 1'b1;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      if (done) dones++;
    end
    check("no_done_after_rst", dones, 0);
    last_addr = '0;

`ifdef MEMSHARE_SCHED_ABORT_EN
    start = 1'b1; step; start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vld = 1'b1; addr_i = AW'(k + 3); step; vld = 1'b0;
      step;
      gnt = 1'b1; step; gnt = 1'b0;
    end
    vld = 1'b1; addr_i = 4'hC; step; vld = 1'b0;
    gtr = 1'b1;
    abort = 1'b1; step; abort = 1'b0; gtr = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_req", req, 0);
    check("abort_delta", delta, 0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      step;
      if (done || busy) dones++;
    end
    check("abort_no_done", dones, 0);
    last_addr = 4'hC;
`endif

    // Randomised operations against the transaction-level model.
    for (int r = 0; r < 20; r++) begin
      isg = 4'($urandom);
      lat = 1;
      d = 1'b0;
      for (int k = 0; k < 4; k++) begin
        vd[k] = 4'($urandom_range(0, 3));
        gd[k] = 4'($urandom_range(0, 3));
        ad[k] = AW'($urandom);
        sh[k] = SW'($urandom);
        lat += 3 + int'(vd[k]) + int'(gd[k]);
        d = d ^ isg[k];
        dexp[k] = d;
      end
      run_op(isg, vd, gd, ad, sh, 1'($urandom), lat, dexp);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step;
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
